// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared RV32 opcode/ALU constants, immediate formats and control bundle.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_MUL   = 5'd8;
    localparam logic [4:0] ALU_OR    = 5'd16;
    localparam logic [4:0] ALU_AND   = 5'd17;
    localparam logic [4:0] ALU_PASSB = 5'd18;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef struct packed {
        logic [4:0] alu;
        logic       we;
        logic       mr;
        logic       mw;
        logic       br;
        logic       jp;
        logic       isel;
        logic       ill;
    } ctrl_t;

    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] imm32(input imm_fmt_e f, input logic [31:0] i);
        case (f)
            IMM_I:   return {{21{i[31]}}, i[30:20]};
            IMM_S:   return {{21{i[31]}}, i[30:25], i[11:7]};
            IMM_B:   return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREGS x XLEN register file, two read ports with write-through bypass, x0 reads zero.
module regfile_bypass #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_wr,
    input  logic [XLEN-1:0]          i_wd,
    input  logic [$clog2(NREGS)-1:0] i_rs1,
    input  logic [$clog2(NREGS)-1:0] i_rs2,
    output logic [XLEN-1:0]          o_rd1,
    output logic [XLEN-1:0]          o_rd2
);
    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk)
        if (rst) r_regs <= '{default: '0};
        else if (i_we && i_wr != '0) r_regs[i_wr] <= i_wd;

    assign o_rd1 = (i_rs1 == '0) ? '0 : (i_we && i_wr == i_rs1) ? i_wd : r_regs[i_rs1];
    assign o_rd2 = (i_rs2 == '0) ? '0 : (i_we && i_wr == i_rs2) ? i_wd : r_regs[i_rs2];
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32 decode stage with registered outputs, load-use stall and bypassed register file.
// Define RV32M_EN to decode MUL..REMU; otherwise those encodings are flagged illegal.
module id_stage_pipe
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_if_valid,
    input  logic [XLEN-1:0]          i_if_pc,
    input  logic [XLEN-1:0]          i_if_pc_plus4,
    input  logic [31:0]              i_if_instruction,
    output logic                     o_id_ready,
    input  logic                     i_flush,
    input  logic                     i_ex_ready,
    input  logic                     i_wb_write_enable,
    input  logic [$clog2(NREGS)-1:0] i_wb_rd,
    input  logic [XLEN-1:0]          i_wb_write_data,
    output logic                     o_id_valid,
    output logic [XLEN-1:0]          o_id_pc,
    output logic [XLEN-1:0]          o_id_pc_plus4,
    output logic [XLEN-1:0]          o_id_read_data1,
    output logic [XLEN-1:0]          o_id_read_data2,
    output logic [XLEN-1:0]          o_id_immediate,
    output logic [$clog2(NREGS)-1:0] o_id_rd,
    output logic [$clog2(NREGS)-1:0] o_id_rs1,
    output logic [$clog2(NREGS)-1:0] o_id_rs2,
    output logic [2:0]               o_id_func3,
    output logic [4:0]               o_id_alu_control,
    output logic                     o_id_write_enable,
    output logic                     o_id_mem_read,
    output logic                     o_id_mem_write,
    output logic                     o_id_branch,
    output logic                     o_id_jump,
    output logic                     o_id_imm_select,
    output logic                     o_id_illegal
);
    localparam int AW = $clog2(NREGS);
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    logic [AW-1:0]   w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0] w_rd1, w_rd2, w_imm;
    imm_fmt_e        w_fmt;
    ctrl_t           w_c, w_ctrl;
    logic            w_legal, w_use1, w_use2, w_adv, w_haz;

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_pc4, r_rd1, r_rd2, r_imm;
    logic [AW-1:0]   r_rd, r_rs1, r_rs2;
    logic [2:0]      r_f3;
    ctrl_t           r_ctrl;

    assign w_opc = i_if_instruction[6:0];
    assign w_f3  = i_if_instruction[14:12];
    assign w_f7  = i_if_instruction[31:25];
    assign w_rd  = i_if_instruction[7 +: AW];
    assign w_rs1 = i_if_instruction[15 +: AW];
    assign w_rs2 = i_if_instruction[20 +: AW];

    regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .i_we  (i_wb_write_enable),
        .i_wr  (i_wb_rd),
        .i_wd  (i_wb_write_data),
        .i_rs1 (w_rs1),
        .i_rs2 (w_rs2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    always_comb begin
        w_c     = '0;
        w_fmt   = IMM_NONE;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        w_legal = 1'b0;
        case (w_opc)
            OPC_LUI:    begin w_legal = 1'b1; w_fmt = IMM_U; w_c.we = 1'b1; w_c.isel = 1'b1; w_c.alu = ALU_PASSB; end
            OPC_AUIPC:  begin w_legal = 1'b1; w_fmt = IMM_U; w_c.we = 1'b1; w_c.isel = 1'b1; end
            OPC_JAL:    begin w_legal = 1'b1; w_fmt = IMM_J; w_c.we = 1'b1; w_c.jp = 1'b1; w_c.isel = 1'b1; end
            OPC_JALR:   begin w_legal = w_f3 == 3'd0; w_fmt = IMM_I; w_use1 = 1'b1; w_c.we = 1'b1; w_c.jp = 1'b1; w_c.isel = 1'b1; end
            OPC_BRANCH: begin w_legal = w_f3[2:1] != 2'b01; w_fmt = IMM_B; w_use1 = 1'b1; w_use2 = 1'b1; w_c.br = 1'b1; w_c.alu = ALU_SUB; end
            OPC_LOAD:   begin w_legal = w_f3 != 3'd3 && w_f3[2:1] != 2'b11; w_fmt = IMM_I; w_use1 = 1'b1; w_c.we = 1'b1; w_c.mr = 1'b1; w_c.isel = 1'b1; end
            OPC_STORE:  begin w_legal = w_f3 < 3'd3; w_fmt = IMM_S; w_use1 = 1'b1; w_use2 = 1'b1; w_c.mw = 1'b1; w_c.isel = 1'b1; end
            OPC_OP_IMM: begin
                w_legal  = (w_f3 == 3'd1) ? w_f7 == 7'h00 : (w_f3 == 3'd5) ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1;
                w_fmt    = IMM_I;
                w_use1   = 1'b1;
                w_c.we   = 1'b1;
                w_c.isel = 1'b1;
                w_c.alu  = alu_base(w_f3, w_f3 == 3'd5 && w_f7[5]);
            end
            OPC_OP: begin
                w_legal = w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)) || (M_EN && w_f7 == 7'h01);
                w_use1  = 1'b1;
                w_use2  = 1'b1;
                w_c.we  = 1'b1;
                w_c.alu = (w_f7 == 7'h01) ? (ALU_MUL | {2'b00, w_f3}) : alu_base(w_f3, w_f7[5]);
            end
            default: ;
        endcase
        w_ctrl = w_c;
        if (!w_legal) begin
            w_ctrl     = '0;
            w_ctrl.ill = 1'b1;
        end
    end

    assign w_imm = XLEN'($signed(imm32(w_fmt, i_if_instruction)));
    assign w_adv = i_ex_ready || !r_valid;
    assign w_haz = r_valid && r_ctrl.mr && r_rd != '0 && ((w_use1 && r_rd == w_rs1) || (w_use2 && r_rd == w_rs2));
    assign o_id_ready = !rst && (i_flush || (w_adv && !w_haz));

    // Reset, flush and load-use bubbles all clear the whole output register.
    always_ff @(posedge clk)
        if (rst || i_flush || (w_adv && w_haz)) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_f3    <= '0;
            r_ctrl  <= '0;
        end else if (w_adv) begin
            r_valid <= i_if_valid;
            r_pc    <= i_if_pc;
            r_pc4   <= i_if_pc_plus4;
            r_rd1   <= w_rd1;
            r_rd2   <= w_rd2;
            r_imm   <= w_imm;
            r_rd    <= w_rd;
            r_rs1   <= w_rs1;
            r_rs2   <= w_rs2;
            r_f3    <= w_f3;
            r_ctrl  <= w_ctrl;
        end

    assign o_id_valid        = r_valid;
    assign o_id_pc           = r_pc;
    assign o_id_pc_plus4     = r_pc4;
    assign o_id_read_data1   = r_rd1;
    assign o_id_read_data2   = r_rd2;
    assign o_id_immediate    = r_imm;
    assign o_id_rd           = r_rd;
    assign o_id_rs1          = r_rs1;
    assign o_id_rs2          = r_rs2;
    assign o_id_func3        = r_f3;
    assign o_id_alu_control  = r_ctrl.alu;
    assign o_id_write_enable = r_ctrl.we;
    assign o_id_mem_read     = r_ctrl.mr;
    assign o_id_mem_write    = r_ctrl.mw;
    assign o_id_branch       = r_ctrl.br;
    assign o_id_jump         = r_ctrl.jp;
    assign o_id_imm_select   = r_ctrl.isel;
    assign o_id_illegal      = r_ctrl.ill;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe against an architectural decode/hazard model.
module tb_id_stage_pipe;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc, pc4, rd1, rd2, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [4:0]  alu;
        logic        we, mr, mw, br, jp, isel, ill;
    } txn_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        we, mr, mw, br, jp, isel, ill, u1, u2;
    } mdec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0, wb_we = 1'b0;
    logic [31:0] if_pc = '0, if_pc4 = '0, instr = '0, wb_data = '0;
    logic [4:0]  wb_rd = '0;
    logic        o_id_ready, o_id_valid;
    logic [31:0] o_id_pc, o_id_pc_plus4, o_id_read_data1, o_id_read_data2, o_id_immediate;
    logic [4:0]  o_id_rd, o_id_rs1, o_id_rs2, o_id_alu_control;
    logic [2:0]  o_id_func3;
    logic        o_id_write_enable, o_id_mem_read, o_id_mem_write, o_id_branch, o_id_jump, o_id_imm_select, o_id_illegal;
    txn_t        w_act;

    int          checks = 0, errors = 0;
    bit          run = 1'b0;
    txn_t        q[$];
    logic [31:0] m_regs [32];
    logic        m_valid = 1'b0;
    logic [4:0]  m_load_rd = '0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_if_valid        (if_valid),
        .i_if_pc           (if_pc),
        .i_if_pc_plus4     (if_pc4),
        .i_if_instruction  (instr),
        .o_id_ready        (o_id_ready),
        .i_flush           (flush),
        .i_ex_ready        (ex_ready),
        .i_wb_write_enable (wb_we),
        .i_wb_rd           (wb_rd),
        .i_wb_write_data   (wb_data),
        .o_id_valid        (o_id_valid),
        .o_id_pc           (o_id_pc),
        .o_id_pc_plus4     (o_id_pc_plus4),
        .o_id_read_data1   (o_id_read_data1),
        .o_id_read_data2   (o_id_read_data2),
        .o_id_immediate    (o_id_immediate),
        .o_id_rd           (o_id_rd),
        .o_id_rs1          (o_id_rs1),
        .o_id_rs2          (o_id_rs2),
        .o_id_func3        (o_id_func3),
        .o_id_alu_control  (o_id_alu_control),
        .o_id_write_enable (o_id_write_enable),
        .o_id_mem_read     (o_id_mem_read),
        .o_id_mem_write    (o_id_mem_write),
        .o_id_branch       (o_id_branch),
        .o_id_jump         (o_id_jump),
        .o_id_imm_select   (o_id_imm_select),
        .o_id_illegal      (o_id_illegal)
    );

    assign w_act = {o_id_pc, o_id_pc_plus4, o_id_read_data1, o_id_read_data2, o_id_immediate,
                    o_id_rd, o_id_rs1, o_id_rs2, o_id_func3, o_id_alu_control,
                    o_id_write_enable, o_id_mem_read, o_id_mem_write, o_id_branch, o_id_jump,
                    o_id_imm_select, o_id_illegal};

    task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    // Reference decode from the ISA tables: ALU code by funct3, alternates for SUB/SRA, M ops at 8+funct3.
    function automatic mdec_t ref_decode(input logic [31:0] ins);
        mdec_t       d;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok;
        int          base [8];
        base = '{0, 2, 3, 4, 5, 6, 16, 17};
        f3 = ins[14:12];
        f7 = ins[31:25];
        d  = '0;
        ok = 1'b0;
        case (ins[6:0])
            7'h37: begin ok = 1; d.imm = ins & 32'hFFFFF000; d.alu = 5'd18; d.we = 1; d.isel = 1; end
            7'h17: begin ok = 1; d.imm = ins & 32'hFFFFF000; d.we = 1; d.isel = 1; end
            7'h6F: begin ok = 1; d.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; d.we = 1; d.jp = 1; d.isel = 1; end
            7'h67: begin ok = f3 == 0; d.imm = 32'($signed(ins) >>> 20); d.we = 1; d.jp = 1; d.isel = 1; d.u1 = 1; end
            7'h63: begin ok = !(f3 == 2 || f3 == 3); d.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; d.br = 1; d.alu = 5'd1; d.u1 = 1; d.u2 = 1; end
            7'h03: begin ok = f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5; d.imm = 32'($signed(ins) >>> 20); d.we = 1; d.mr = 1; d.isel = 1; d.u1 = 1; end
            7'h23: begin ok = f3 <= 2; d.imm = {{21{ins[31]}}, ins[30:25], ins[11:7]}; d.mw = 1; d.isel = 1; d.u1 = 1; d.u2 = 1; end
            7'h13: begin
                ok = (f3 == 1) ? f7 == 0 : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
                d.imm = 32'($signed(ins) >>> 20); d.we = 1; d.isel = 1; d.u1 = 1;
                d.alu = 5'(base[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0));
            end
            7'h33: begin
                d.we = 1; d.u1 = 1; d.u2 = 1;
                if (f7 == 0) begin ok = 1; d.alu = 5'(base[f3]); end
                else if (f7 == 32 && f3 == 0) begin ok = 1; d.alu = 5'd1; end
                else if (f7 == 32 && f3 == 5) begin ok = 1; d.alu = 5'd7; end
                else if (f7 == 1) begin ok = M_EN; d.alu = 5'(8 + f3); end
            end
            default: ;
        endcase
        if (!ok) begin
            {d.alu, d.we, d.mr, d.mw, d.br, d.jp, d.isel} = '0;
            d.ill = 1'b1;
        end
        return d;
    endfunction

    // Predictor: tracks what the output register should hold and the architectural registers.
    always @(negedge clk) begin : pred
        mdec_t      d;
        txn_t       t;
        logic       adv, haz;
        logic [4:0] a1, a2;
        if (run) begin
            if (rst) begin
                chk("ready_in_reset", 256'(o_id_ready), 256'(0));
                m_valid   = 1'b0;
                m_load_rd = '0;
                foreach (m_regs[i]) m_regs[i] = '0;
            end else begin
                chk("valid", 256'(o_id_valid), 256'(m_valid));
                d   = ref_decode(instr);
                a1  = instr[19:15];
                a2  = instr[24:20];
                adv = ex_ready || !m_valid;
                haz = m_load_rd != 0 && ((d.u1 && a1 == m_load_rd) || (d.u2 && a2 == m_load_rd));
                chk("ready", 256'(o_id_ready), 256'(flush || (adv && !haz)));
                if (flush || (adv && haz)) begin
                    m_valid   = 1'b0;
                    m_load_rd = '0;
                end else if (adv) begin
                    m_valid   = if_valid;
                    m_load_rd = (if_valid && d.mr) ? instr[11:7] : 5'd0;
                    if (if_valid) begin
                        t.pc   = if_pc;
                        t.pc4  = if_pc4;
                        t.rd1  = (a1 == 0) ? 32'd0 : (wb_we && wb_rd == a1) ? wb_data : m_regs[a1];
                        t.rd2  = (a2 == 0) ? 32'd0 : (wb_we && wb_rd == a2) ? wb_data : m_regs[a2];
                        t.imm  = d.imm;
                        t.rd   = instr[11:7];
                        t.rs1  = a1;
                        t.rs2  = a2;
                        t.f3   = instr[14:12];
                        t.alu  = d.alu;
                        t.we   = d.we;
                        t.mr   = d.mr;
                        t.mw   = d.mw;
                        t.br   = d.br;
                        t.jp   = d.jp;
                        t.isel = d.isel;
                        t.ill  = d.ill;
                        q.push_back(t);
                    end
                end
                if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
            end
        end
    end

    // Monitor: every instruction execute consumes must match the oldest prediction.
    always @(negedge clk) begin : mon
        txn_t e;
        if (run) begin
            if (rst || flush) q.delete();
            else if (o_id_valid && ex_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got %0h want none", w_act);
                end else begin
                    e = q.pop_front();
                    chk("txn", 256'(w_act), 256'(e));
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic er,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd, input logic r);
        @(posedge clk);
        #1;
        rst      = r;
        if_valid = v;
        instr    = ins;
        flush    = fl;
        ex_ready = er;
        wb_we    = we;
        wb_rd    = wr;
        wb_data  = wd;
        if_pc    = $urandom & 32'hFFFFFFFC;
        if_pc4   = if_pc + 32'd4;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [6:0]  ops [9];
        logic [6:0]  f7s [3];
        logic [31:0] ins;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        f7s = '{7'h00, 7'h20, 7'h01};
        ins = $urandom;
        k   = $urandom_range(0, 12);
        ins[6:0]   = (k < 9) ? ops[k] : (k < 12) ? 7'h03 : 7'($urandom);
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) ins[31:25] = f7s[$urandom_range(0, 2)];
        return ins;
    endfunction

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] ADD3 = 32'h002101B3;
    localparam logic [31:0] ADD5 = 32'h000202B3;
    localparam logic [31:0] MUL6 = 32'h02208333;

    initial begin
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        run = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        idle();
        @(negedge clk);
        chk("reset_outputs", 256'({o_id_valid, w_act}), 256'(0));
        chk("ready_after_reset", 256'(o_id_ready), 256'(1));

        cyc(1'b1, ADDI, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        idle();
        @(negedge clk);
        chk("addi_imm", 256'(o_id_immediate), 256'(5));
        chk("addi_rd", 256'(o_id_rd), 256'(1));
        chk("addi_illegal", 256'(o_id_illegal), 256'(0));

        cyc(1'b1, LW, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        cyc(1'b1, ADD3, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("loaduse_ready", 256'(o_id_ready), 256'(0));
        cyc(1'b1, ADD3, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("bubble_valid", 256'(o_id_valid), 256'(0));
        idle();
        @(negedge clk);
        chk("add_rs", 256'({o_id_valid, o_id_rs1, o_id_rs2}), 256'({1'b1, 5'd2, 5'd2}));

        cyc(1'b1, ADD5, 1'b0, 1'b1, 1'b1, 5'd4, 32'hDEADBEEF, 1'b0);
        idle();
        @(negedge clk);
        chk("bypass_rd1", 256'(o_id_read_data1), 256'(32'hDEADBEEF));
        chk("bypass_rd2", 256'(o_id_read_data2), 256'(0));

        cyc(1'b1, ADDI, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        cyc(1'b1, ADD5, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("hold_ready", 256'(o_id_ready), 256'(0));
        chk("hold_imm", 256'(o_id_immediate), 256'(5));
        cyc(1'b1, ADD5, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("flush_valid", 256'(o_id_valid), 256'(0));

        cyc(1'b1, MUL6, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        idle();
        @(negedge clk);
        chk("mul_alu", 256'(o_id_alu_control), 256'(M_EN ? 8 : 0));
        chk("mul_illegal", 256'(o_id_illegal), 256'(M_EN ? 0 : 1));

        cyc(1'b1, LW, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        cyc(1'b1, ADD3, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        idle();
        @(negedge clk);
        chk("rst_stall_outputs", 256'({o_id_valid, w_act}), 256'(0));
        chk("rst_stall_ready", 256'(o_id_ready), 256'(1));

        for (int n = 0; n < 2000; n++)
            cyc($urandom_range(0, 9) < 8, rnd_ins(), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 199) == 0);

        for (int n = 0; n < 4; n++) idle();
        @(negedge clk);
        chk("queue_drained", 256'(q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
